nec_bus_ctrl: RTL and testbench

- Bus-cycle sequencer between the NEC V30 local bus and the DDRAM port.
- Latches the multiplexed address on ASTB, classifies each cycle as memory or I/O and read or write.
- Memory cycles become single-beat 64-bit DDRAM reads or byte-masked writes; NEC READY is held low until the DDRAM side completes.
- Sits between the top-level AD tristate buffer and the DDRAM arbiter port; replaces the current tie-offs of READY, AD_DIR and DDRAM.

---
 rtl/nec_bus_pkg.sv | 39 +++
 rtl/nec_bus_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_nec_bus_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nec_bus_pkg.sv
// nec_bus_pkg
//   Shared types and helpers for the NEC V30 bus-cycle sequencer.
//   - bus_state_t : sequencer states
//   - DDR_AW      : DDRAM 64-bit word-address width
//   - lane_of     : 16-bit lane within a 64-bit word for a CPU byte address
//   - lane_be     : 8-bit DDRAM byte enable for a 16-bit CPU access
//   - lane_data   : 16-bit lane extracted from a 64-bit DDRAM word
package nec_bus_pkg;

    localparam int DDR_AW = 29;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        IO_RD,
        DONE
    } bus_state_t;

    function automatic logic [1:0] lane_of(input logic [19:0] addr);
        return addr[2:1];
    endfunction

    // be16 bit1 = high byte (UBE), bit0 = low byte (A0 == 0)
    function automatic logic [7:0] lane_be(input logic [1:0] lane,
                                           input logic       ube,
                                           input logic       a0);
        logic [7:0] be16;
        be16 = {6'b0, ube, ~a0};
        return be16 << {lane, 1'b0};
    endfunction

    function automatic logic [15:0] lane_data(input logic [63:0] word,
                                              input logic [1:0]  lane);
        return word[16*lane +: 16];
    endfunction

endpackage

// File: rtl/nec_bus_ctrl.sv
// nec_bus_ctrl
//   Sequences NEC V30 local-bus cycles onto a single-beat 64-bit DDRAM port.
//   The multiplexed address is latched while ASTB is high; memory reads
//   become one DDRAM read, memory writes one byte-masked DDRAM write, and
//   NEC READY is held low until the DDRAM side completes. I/O reads return
//   a constant, I/O writes are dropped.
//
//   Ports:
//     clk, reset          system clock, synchronous active-low reset
//     ad_in/ad_out/ad_oe  sampled NEC_AD, read data, FPGA drive enable
//     astb, rd_n, wr_n,
//     io_n, ube_n         NEC strobes and cycle qualifiers
//     ready               NEC_READY
//     ddr_*               DDRAM arbiter port
//     timeout_err         sticky flag, a DDRAM read was abandoned
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   IDLE    | waiting for an RD/WR strobe fall
//   RD_REQ  | memory read pending, waiting for ddr_busy=0
//   RD_WAIT | read issued, waiting for ddr_dout_ready or timeout
//   WR_REQ  | memory write pending / issued, ready released after pulse
//   IO_RD   | I/O read, present IO_RDATA
//   DONE    | cycle finished, waiting for both strobes high
module nec_bus_ctrl
    import nec_bus_pkg::*;
#(
    parameter logic [DDR_AW-1:0] DDRAM_BASE = 29'h0300_0000,
    parameter logic [15:0]       IO_RDATA   = 16'hFFFF,
    parameter int                TIMEOUT    = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [19:0]       ad_in,
    output logic [15:0]       ad_out,
    output logic              ad_oe,
    input  logic              astb,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic              io_n,
    input  logic              ube_n,
    output logic              ready,
    input  logic              ddr_busy,
    output logic [DDR_AW-1:0] ddr_addr,
    output logic              ddr_rd,
    output logic              ddr_we,
    output logic [7:0]        ddr_be,
    output logic [63:0]       ddr_din,
    input  logic [63:0]       ddr_dout,
    input  logic              ddr_dout_ready,
    output logic              timeout_err
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_TC = CW'(TIMEOUT);

    bus_state_t        state_q, state_d;
    logic              rd_n_q, rd_n_p_q, wr_n_q, wr_n_p_q, astb_q, io_n_q;
    logic [19:0]       addr_q, addr_d;
    logic              io_q, io_d;
    logic              ube_q, ube_d;
    logic              ready_q, ready_d;
    logic              ad_oe_q, ad_oe_d;
    logic [15:0]       ad_out_q, ad_out_d;
    logic              ddr_rd_q, ddr_rd_d;
    logic              ddr_we_q, ddr_we_d;
    logic [7:0]        ddr_be_q, ddr_be_d;
    logic [DDR_AW-1:0] ddr_addr_q, ddr_addr_d;
    logic [63:0]       ddr_din_q, ddr_din_d;
    logic              timeout_err_q, timeout_err_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [DDR_AW-1:0] wa;
    logic [1:0]        lane;
    logic              rd_fall, wr_fall;

    assign wa      = DDRAM_BASE + DDR_AW'(addr_q[19:3]);
    assign lane    = lane_of(addr_q);
    assign rd_fall = rd_n_p_q & ~rd_n_q;
    assign wr_fall = wr_n_p_q & ~wr_n_q;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        io_d          = io_q;
        ube_d         = ube_q;
        ready_d       = ready_q;
        ad_oe_d       = ad_oe_q;
        ad_out_d      = ad_out_q;
        ddr_rd_d      = 1'b0;
        ddr_we_d      = 1'b0;
        ddr_be_d      = ddr_be_q;
        ddr_addr_d    = ddr_addr_q;
        ddr_din_d     = ddr_din_q;
        timeout_err_d = timeout_err_q;
        cnt_d         = cnt_q;

        if (astb_q) begin
            addr_d = ad_in;
            io_d   = ~io_n_q;
            ube_d  = ~ube_n;
        end

        case (state_q)
            IDLE: begin
                if (rd_fall) begin
                    if (io_q) begin
                        state_d = IO_RD;
                    end else begin
                        state_d = RD_REQ;
                        ready_d = 1'b0;
                    end
                end else if (wr_fall) begin
                    if (io_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = WR_REQ;
                        ready_d = 1'b0;
                    end
                end
            end
            RD_REQ: begin
                if (!ddr_busy) begin
                    ddr_rd_d   = 1'b1;
                    ddr_addr_d = wa;
                    cnt_d      = '0;
                    state_d    = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (ddr_dout_ready) begin
                    ad_out_d = lane_data(ddr_dout, lane);
                    ad_oe_d  = 1'b1;
                    ready_d  = 1'b1;
                    state_d  = DONE;
                end else if (cnt_q == CNT_TC) begin
                    ad_out_d      = 16'hFFFF;
                    ad_oe_d       = 1'b1;
                    ready_d       = 1'b1;
                    timeout_err_d = 1'b1;
                    state_d       = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WR_REQ: begin
                // The pulse is registered: release ready on the cycle the
                // write strobe is actually presented to the DDRAM port.
                if (ddr_we_q) begin
                    ready_d = 1'b1;
                    state_d = DONE;
                end else if (!ddr_busy) begin
                    ddr_we_d   = 1'b1;
                    ddr_addr_d = wa;
                    ddr_be_d   = lane_be(lane, ube_q, addr_q[0]);
                    ddr_din_d  = {4{ad_in[15:0]}};
                end
            end
            IO_RD: begin
                ad_out_d = IO_RDATA;
                ad_oe_d  = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                if (rd_n_q && wr_n_q) begin
                    ad_oe_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            rd_n_q        <= 1'b1;
            rd_n_p_q      <= 1'b1;
            wr_n_q        <= 1'b1;
            wr_n_p_q      <= 1'b1;
            astb_q        <= 1'b0;
            io_n_q        <= 1'b1;
            addr_q        <= '0;
            io_q          <= 1'b0;
            ube_q         <= 1'b0;
            ready_q       <= 1'b1;
            ad_oe_q       <= 1'b0;
            ad_out_q      <= '0;
            ddr_rd_q      <= 1'b0;
            ddr_we_q      <= 1'b0;
            ddr_be_q      <= '0;
            ddr_addr_q    <= '0;
            ddr_din_q     <= '0;
            timeout_err_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            rd_n_q        <= rd_n;
            rd_n_p_q      <= rd_n_q;
            wr_n_q        <= wr_n;
            wr_n_p_q      <= wr_n_q;
            astb_q        <= astb;
            io_n_q        <= io_n;
            addr_q        <= addr_d;
            io_q          <= io_d;
            ube_q         <= ube_d;
            ready_q       <= ready_d;
            ad_oe_q       <= ad_oe_d;
            ad_out_q      <= ad_out_d;
            ddr_rd_q      <= ddr_rd_d;
            ddr_we_q      <= ddr_we_d;
            ddr_be_q      <= ddr_be_d;
            ddr_addr_q    <= ddr_addr_d;
            ddr_din_q     <= ddr_din_d;
            timeout_err_q <= timeout_err_d;
            cnt_q         <= cnt_d;
        end
    end

    assign ad_out      = ad_out_q;
    assign ad_oe       = ad_oe_q;
    assign ready       = ready_q;
    assign ddr_addr    = ddr_addr_q;
    assign ddr_rd      = ddr_rd_q;
    assign ddr_we      = ddr_we_q;
    assign ddr_be      = ddr_be_q;
    assign ddr_din     = ddr_din_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_nec_bus_ctrl.sv
// tb_nec_bus_ctrl
//   Scoreboard bench for nec_bus_ctrl: a small DDRAM responder model,
//   bus-cycle driver tasks and one task per scenario.
module tb_nec_bus_ctrl;

    localparam logic [28:0] BASE = 29'h0300_0000;
    localparam logic [15:0] IOD  = 16'hC0DE;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [19:0] ad_in = '0;
    logic [15:0] ad_out;
    logic        ad_oe;
    logic        astb = 1'b0, rd_n = 1'b1, wr_n = 1'b1, io_n = 1'b1, ube_n = 1'b1;
    logic        ready;
    logic        ddr_busy = 1'b0;
    logic [28:0] ddr_addr;
    logic        ddr_rd, ddr_we;
    logic [7:0]  ddr_be;
    logic [63:0] ddr_din;
    logic [63:0] ddr_dout = '0;
    logic        ddr_dout_ready = 1'b0;
    logic        timeout_err;

    nec_bus_ctrl #(.DDRAM_BASE(BASE), .IO_RDATA(IOD), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe),
        .astb(astb), .rd_n(rd_n), .wr_n(wr_n), .io_n(io_n), .ube_n(ube_n),
        .ready(ready), .ddr_busy(ddr_busy), .ddr_addr(ddr_addr), .ddr_rd(ddr_rd),
        .ddr_we(ddr_we), .ddr_be(ddr_be), .ddr_din(ddr_din), .ddr_dout(ddr_dout),
        .ddr_dout_ready(ddr_dout_ready), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    typedef struct {logic [28:0] addr; logic [15:0] data;} rd_exp_t;
    typedef struct {logic [28:0] addr; logic [7:0] be; logic [63:0] din;} wr_exp_t;
    rd_exp_t rd_sb[$];
    wr_exp_t wr_sb[$];

    // DDRAM responder: data comes back three clocks after the read pulse.
    int          rsp_cnt = 0;
    bit          rsp_en = 1'b1;
    logic [63:0] mem_word = '0;
    always @(negedge clk) begin
        ddr_dout_ready = 1'b0;
        if (ddr_rd) rsp_cnt = 3;
        else if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0 && rsp_en) begin
                ddr_dout_ready = 1'b1;
                ddr_dout       = mem_word;
            end
        end
    end

    int rd_pulses = 0, we_pulses = 0, ready_low = 0, both_hi = 0;
    always @(negedge clk) begin
        if (ddr_rd) rd_pulses++;
        if (ddr_we) we_pulses++;
        if (ready === 1'b0) ready_low++;
        if (ddr_rd && ddr_we) both_hi++;
    end

    task automatic addr_phase(input logic [19:0] a, input logic io_n_v, input logic ube_n_v);
        @(negedge clk);
        ad_in = a; io_n = io_n_v; ube_n = ube_n_v; astb = 1'b1;
        @(negedge clk);
        astb = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic mem_read(input logic [19:0] a, input logic [63:0] word,
                            input logic [15:0] exp, input int busy_cyc,
                            input bit mute, input string nm);
        rd_exp_t e;
        int r0, lo0;
        bit seen;
        e.addr = BASE + 29'(a[19:3]);
        e.data = exp;
        rd_sb.push_back(e);
        mem_word = word;
        rsp_en   = !mute;
        addr_phase(a, 1'b1, 1'b0);
        r0 = rd_pulses; lo0 = ready_low;
        if (busy_cyc > 0) ddr_busy = 1'b1;
        rd_n = 1'b0;
        if (busy_cyc > 0) begin
            repeat (busy_cyc) @(negedge clk);
            nvec++;
            if (rd_pulses != r0 || ready !== 1'b0) begin
                nerr++;
                $display("FAIL %s_stall: rd_pulses=%0d ready=%b, required 0 pulses ready=0",
                         nm, rd_pulses - r0, ready);
            end
            ddr_busy = 1'b0;
        end
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ddr_rd === 1'b1) begin seen = 1; break; end
        end
        e = rd_sb.pop_front();
        nvec++;
        if (!seen || ddr_addr !== e.addr) begin
            nerr++;
            $display("FAIL %s_addr: ddr_rd seen=%0d ddr_addr=%h, required %h", nm, seen, ddr_addr, e.addr);
        end
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ready === 1'b1) begin seen = 1; break; end
        end
        nvec++;
        if (!seen || ad_out !== e.data || ad_oe !== 1'b1) begin
            nerr++;
            $display("FAIL %s_data: ready=%b ad_out=%h ad_oe=%b, required ready=1 ad_out=%h ad_oe=1",
                     nm, ready, ad_out, ad_oe, e.data);
        end
        if (busy_cyc == 0 && !mute) begin
            nvec++;
            if (ready_low - lo0 < 4 || ready_low - lo0 > 6) begin
                nerr++;
                $display("FAIL %s_latency: ready low %0d clk, required 4..6", nm, ready_low - lo0);
            end
        end
        @(negedge clk);
        rd_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ad_oe === 1'b0) begin seen = 1; break; end
        end
        nvec++;
        if (!seen || rd_pulses - r0 != 1) begin
            nerr++;
            $display("FAIL %s_release: ad_oe=%b rd_pulses=%0d, required ad_oe=0 within 3 clk, 1 pulse",
                     nm, ad_oe, rd_pulses - r0);
        end
        rsp_en = 1'b1;
    endtask

    task automatic mem_write(input logic [19:0] a, input logic ube_n_v, input logic [15:0] data,
                             input logic [7:0] exp_be, input string nm);
        wr_exp_t e;
        int w0, lo0;
        bit seen;
        e.addr = BASE + 29'(a[19:3]);
        e.be   = exp_be;
        e.din  = {data, data, data, data};
        wr_sb.push_back(e);
        addr_phase(a, 1'b1, ube_n_v);
        w0 = we_pulses; lo0 = ready_low;
        ad_in = {4'h0, data};
        wr_n  = 1'b0;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ddr_we === 1'b1) begin seen = 1; break; end
        end
        e = wr_sb.pop_front();
        nvec++;
        if (!seen || ddr_addr !== e.addr || ddr_be !== e.be || ddr_din !== e.din) begin
            nerr++;
            $display("FAIL %s_port: we=%0d addr=%h be=%h din=%h, required addr=%h be=%h din=%h",
                     nm, seen, ddr_addr, ddr_be, ddr_din, e.addr, e.be, e.din);
        end
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ready === 1'b1) begin seen = 1; break; end
        end
        wr_n = 1'b1;
        repeat (4) @(negedge clk);
        nvec++;
        if (!seen || we_pulses - w0 != 1 || ready_low - lo0 < 2 || ad_oe !== 1'b0) begin
            nerr++;
            $display("FAIL %s_done: ready_seen=%0d we_pulses=%0d ready_low=%0d ad_oe=%b, required 1, 1, >=2, 0",
                     nm, seen, we_pulses - w0, ready_low - lo0, ad_oe);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            astb = ~astb; rd_n = ~rd_n; wr_n = ~wr_n;
        end
        @(negedge clk);
        nvec++;
        if (ready !== 1'b1 || ad_oe !== 1'b0 || ddr_rd !== 1'b0 || ddr_we !== 1'b0 ||
            timeout_err !== 1'b0 || ad_out !== 16'h0 || ddr_be !== 8'h0 ||
            ddr_addr !== 29'h0 || ddr_din !== 64'h0) begin
            nerr++;
            $display("FAIL reset: ready=%b ad_oe=%b rd=%b we=%b terr=%b ad_out=%h be=%h addr=%h din=%h, required 1 0 0 0 0 0 0 0 0",
                     ready, ad_oe, ddr_rd, ddr_we, timeout_err, ad_out, ddr_be, ddr_addr, ddr_din);
        end
        astb = 1'b0; rd_n = 1'b1; wr_n = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_word_read();
        mem_read(20'h00012, 64'h4444_3333_2222_1111, 16'h2222, 0, 1'b0, "word_read");
    endtask

    task automatic test_back_to_back();
        mem_read(20'h00000, 64'h8888_7777_6666_5555, 16'h5555, 0, 1'b0, "b2b_lane0");
        mem_read(20'h0001E, 64'h8888_7777_6666_5555, 16'h8888, 0, 1'b0, "b2b_lane3");
    endtask

    task automatic test_writes();
        mem_write(20'h00007, 1'b0, 16'hAB00, 8'h80, "odd_byte_wr");
        mem_write(20'h0000C, 1'b0, 16'h1234, 8'h30, "word_wr");
        mem_write(20'h00002, 1'b1, 16'h00CD, 8'h04, "low_byte_wr");
    endtask

    task automatic test_busy_stall();
        mem_read(20'h00024, 64'hDEAD_BEEF_CAFE_F00D, 16'hBEEF, 10, 1'b0, "busy_read");
    endtask

    task automatic test_timeout();
        mem_read(20'h00040, 64'h0, 16'hFFFF, 0, 1'b1, "timeout_read");
        nvec++;
        if (timeout_err !== 1'b1) begin
            nerr++;
            $display("FAIL timeout_flag: timeout_err=%b, required 1", timeout_err);
        end
        mem_read(20'h00008, 64'h4444_3333_2222_1111, 16'h1111, 0, 1'b0, "post_timeout_read");
        nvec++;
        if (timeout_err !== 1'b1) begin
            nerr++;
            $display("FAIL timeout_sticky: timeout_err=%b, required 1", timeout_err);
        end
    endtask

    task automatic test_io();
        int r0, w0, lo0;
        bit seen;
        addr_phase(20'h00080, 1'b0, 1'b0);
        r0 = rd_pulses; lo0 = ready_low;
        rd_n = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ad_oe === 1'b1) begin seen = 1; break; end
        end
        nvec++;
        if (!seen || ad_out !== IOD || ready_low != lo0 || rd_pulses != r0) begin
            nerr++;
            $display("FAIL io_read: ad_oe_seen=%0d ad_out=%h ready_low=%0d rd_pulses=%0d, required ad_out=%h, 0, 0",
                     seen, ad_out, ready_low - lo0, rd_pulses - r0, IOD);
        end
        rd_n = 1'b1;
        repeat (4) @(negedge clk);
        addr_phase(20'h00090, 1'b0, 1'b0);
        w0 = we_pulses; lo0 = ready_low;
        ad_in = 20'h05555;
        wr_n  = 1'b0;
        repeat (8) @(negedge clk);
        wr_n = 1'b1;
        repeat (4) @(negedge clk);
        nvec++;
        if (we_pulses != w0 || ready_low != lo0 || ad_oe !== 1'b0) begin
            nerr++;
            $display("FAIL io_write: we_pulses=%0d ready_low=%0d ad_oe=%b, required 0, 0, 0",
                     we_pulses - w0, ready_low - lo0, ad_oe);
        end
    endtask

    task automatic test_reset_abort();
        rsp_en = 1'b0;
        addr_phase(20'h00100, 1'b1, 1'b0);
        rd_n = 1'b0;
        repeat (6) @(negedge clk);
        nvec++;
        if (ready !== 1'b0) begin
            nerr++;
            $display("FAIL abort_inflight: ready=%b, required 0", ready);
        end
        reset = 1'b0;
        rd_n  = 1'b1;
        repeat (2) @(negedge clk);
        nvec++;
        if (ready !== 1'b1 || ad_oe !== 1'b0 || timeout_err !== 1'b0 || ddr_rd !== 1'b0) begin
            nerr++;
            $display("FAIL abort_reset: ready=%b ad_oe=%b terr=%b rd=%b, required 1 0 0 0",
                     ready, ad_oe, timeout_err, ddr_rd);
        end
        reset = 1'b1;
        repeat (24) @(negedge clk);
        rsp_en = 1'b1;
        mem_read(20'h00012, 64'h4444_3333_2222_1111, 16'h2222, 0, 1'b0, "post_abort_read");
    endtask

    task automatic test_exclusive();
        nvec++;
        if (both_hi != 0) begin
            nerr++;
            $display("FAIL rd_we_exclusive: overlap cycles=%0d, required 0", both_hi);
        end
    endtask

    initial begin
        test_reset();
        test_word_read();
        test_back_to_back();
        test_writes();
        test_busy_stall();
        test_timeout();
        test_io();
        test_reset_abort();
        test_exclusive();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
